conv_result_reader: RTL and testbench

- Read-back engine for the convolution datapath.
- After the convolution core has written its result words into the 512x32 Memory, this block drives the same Memory port (index/wr/in/out) as a read-only initiator.
- It fetches a contiguous range of words and streams them out on a valid/ready interface to the bench or host.
- It is the reader counterpart to the core's memory writer and shares the Memory through the top-level port mux.

---
 rtl/conv_result_reader_pkg.sv | 18 +
 rtl/conv_result_reader_fifo2.sv | 60 ++++++
 rtl/conv_result_reader.sv | 104 ++++++++++
 tb/tb_conv_result_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/conv_result_reader_pkg.sv
// Shared definitions for the convolution result read-back engine.
//   ADDR_W / DATA_W : Memory index and word widths (512 x 32 Memory)
//   MEM_DEPTH       : number of Memory words
//   rr_state_t      : read-back FSM state encoding
package conv_result_reader_pkg;

   localparam int unsigned ADDR_W    = 9;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MEM_DEPTH = 512;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } rr_state_t;

endpackage

// File: rtl/conv_result_reader_fifo2.sv
// rr_fifo2: 2-entry synchronous FIFO used as the output skid buffer.
//   clk, rst  : clock, asynchronous active-high reset (empties FIFO, head=0)
//   push, din : write din at the clock edge (ignored when full without pop)
//   pop       : drop the head entry (ignored when empty)
//   head      : current head word; holds its last value while empty
//   occupancy : number of stored entries, 0..2
module rr_fifo2
   import conv_result_reader_pkg::*;
#(
   parameter int unsigned DATA_W = conv_result_reader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        occupancy
);

   logic [DATA_W-1:0] head_q;
   logic [DATA_W-1:0] tail_q;
   logic [1:0]        occ_q;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop && (occ_q != 2'd0);
   assign do_push = push && ((occ_q != 2'd2) || do_pop);

   // Head is a dedicated register rather than a pointer into storage so
   // that it keeps the last popped word while the FIFO is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         case (occ_q)
            2'd0: begin
               if (do_push) head_q <= din;
            end
            2'd1: begin
               if (do_push && do_pop) head_q <= din;
               else if (do_push)      tail_q <= din;
            end
            default: begin
               if (do_pop) begin
                  head_q <= tail_q;
                  if (do_push) tail_q <= din;
               end
            end
         endcase
         occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head      = head_q;
   assign occupancy = occ_q;

endmodule

// File: rtl/conv_result_reader.sv
// conv_result_reader: streams a contiguous range of Memory words out on a
// valid/ready interface, acting as a read-only Memory initiator.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a read-back (sampled only in IDLE)
//   base_addr, count    : first word index and word count (0..512)
//   mem_index/mem_wr/mem_in/mem_out : Memory port (never writes)
//   dout, dout_valid, dout_ready    : output stream
//   busy                : high outside IDLE (top-level mux select)
//   done                : one-cycle pulse after the last word is accepted
module conv_result_reader
   import conv_result_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = conv_result_reader_pkg::ADDR_W,
   parameter int unsigned DATA_W = conv_result_reader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] mem_index,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] REM_ONE = 1;

   rr_state_t         state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W:0]   remaining, rem_nxt;
   logic [1:0]        occ;
   logic              push;
   logic              pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         remaining <= rem_nxt;
      end
   end

   assign pop = dout_valid && dout_ready;

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      rem_nxt   = remaining;
      push      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               addr_nxt  = base_addr;
               rem_nxt   = count;
               state_nxt = (count == '0) ? ST_FIN : ST_READ;
            end
         end
         ST_READ: begin
            // A full FIFO can still take a word when its head leaves this cycle.
            push = (occ != 2'd2) || pop;
            if (push) begin
               addr_nxt = addr + 1'b1;
               rem_nxt  = remaining - 1'b1;
               if (remaining == REM_ONE) state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((occ == 2'd0) || ((occ == 2'd1) && pop)) state_nxt = ST_FIN;
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   rr_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (mem_out),
      .head      (dout),
      .occupancy (occ)
   );

   assign dout_valid = (occ != 2'd0);
   assign mem_index  = addr;
   assign mem_wr     = 1'b0;
   assign mem_in     = '0;
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_conv_result_reader.sv
module tb_conv_result_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  base_addr = '0;
   logic [9:0]  count = '0;
   logic [8:0]  mem_index;
   logic        mem_wr;
   logic [31:0] mem_in;
   logic [31:0] mem_out;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        busy;
   logic        done;

   logic [31:0] mem [512];
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   assign mem_out = mem[mem_index];

   conv_result_reader #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .mem_index  (mem_index),
      .mem_wr     (mem_wr),
      .mem_in     (mem_in),
      .mem_out    (mem_out),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // rmode: 0 = ready always high, 1 = random ready, 2 = ready low for 5 cycles from first valid
   task automatic run_xfer(input int unsigned base, input int unsigned cnt, input int unsigned rmode,
                           input bit busy_start, input int unsigned abort_after);
      logic [31:0] exp_q[$];
      int unsigned c = 0;
      int unsigned acc = 0;
      int unsigned last_acc = 0;
      int unsigned dones = 0;
      bit seen_valid = 1'b0;
      bit post_done = 1'b0;
      bit finished = 1'b0;
      bit aborted = 1'b0;
      for (int unsigned i = 0; i < cnt; i++) exp_q.push_back(mem[(base + i) % 512]);

      @(negedge clk);
      start = 1'b1;
      base_addr = 9'(base);
      count = 10'(cnt);
      @(negedge clk);
      start = 1'b0;

      while (!finished && c < 4000) begin
         case (rmode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = !(c >= 1 && c <= 5);
         endcase
         if (busy_start && c == 1) begin
            start = 1'b1;
            base_addr = 9'd100;
            count = 10'd4;
         end else begin
            start = 1'b0;
         end

         if (abort_after != 0 && acc >= abort_after) begin
            rst = 1'b1;
            #1;
            check("abort_valid", 32'(dout_valid), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_dout", dout, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
               #1;
               check("abort_nodone", 32'(done), 0);
               @(negedge clk);
            end
            aborted = 1'b1;
            finished = 1'b1;
         end else begin
            #1;
            check("mem_wr", {31'd0, mem_wr}, 0);
            check("mem_in", mem_in, 0);
            if (post_done) begin
               check("busy_after_done", 32'(busy), 0);
               finished = 1'b1;
            end else begin
               if (dout_valid && !seen_valid) begin
                  seen_valid = 1'b1;
                  check("first_valid_lat", c, 1);
               end
               if (cnt == 0) begin
                  check("zero_valid", 32'(dout_valid), 0);
                  check("zero_index", 32'(mem_index), base);
               end
               if (rmode == 0 && c < cnt) check("index_seq", 32'(mem_index), (base + c) % 512);
               if (rmode == 2 && c >= 1 && c <= 5 && exp_q.size() != 0) begin
                  check("stall_dout", dout, exp_q[0]);
                  if (c == 5) check("stall_index", 32'(mem_index), (base + 2) % 512);
               end
               if (done) begin
                  dones++;
                  check("done_cycle", c, (cnt == 0) ? 0 : last_acc + 1);
                  check("done_words", acc, cnt);
                  check("busy_with_done", 32'(busy), 1);
                  post_done = 1'b1;
               end
               if (dout_valid && dout_ready) begin
                  if (exp_q.size() == 0) begin
                     check("extra_word", dout, 32'hDEAD_BEEF);
                  end else begin
                     check("word", dout, exp_q.pop_front());
                  end
                  acc++;
                  last_acc = c;
               end
            end
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      if (!finished) check("timeout", 1, 0);
      if (!aborted) begin
         check("done_count", dones, 1);
         check("all_words", exp_q.size(), 0);
      end
   endtask

   initial begin
      logic [8:0] zb;
      for (int unsigned i = 0; i < 512; i++) mem[i] = $urandom;
      for (int unsigned i = 0; i < 4; i++) mem[5 + i] = 32'hA0 + i;
      mem[510] = 1; mem[511] = 2; mem[0] = 3; mem[1] = 4;

      repeat (3) @(negedge clk);
      #1;
      check("rst_index", 32'(mem_index), 0);
      check("rst_dout", dout, 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      run_xfer(5, 4, 0, 1'b0, 0);
      run_xfer(5, 4, 2, 1'b0, 0);
      run_xfer(510, 4, 0, 1'b0, 0);
      #1 zb = mem_index;
      run_xfer(zb, 0, 0, 1'b0, 0);
      run_xfer(5, 4, 0, 1'b1, 0);
      run_xfer(5, 4, 0, 1'b0, 2);
      run_xfer(5, 1, 0, 1'b0, 0);
      for (int unsigned t = 0; t < 6; t++)
         run_xfer($urandom_range(0, 511), $urandom_range(1, 40), 1, 1'b0, 0);
      run_xfer($urandom_range(0, 511), 512, 1, 1'b0, 0);
      run_xfer($urandom_range(0, 511), 512, 0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
